// File: rtl/miriscv_mdu_arb.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_mdu_arb
// Purpose  : Round-robin arbiter sharing one multiply/divide unit between two
//            requesters, with per-requester flush and response routing.
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_mdu_arb #(
  parameter int XLEN         = 32,
  parameter int MDU_OP_WIDTH = 3
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [2*XLEN-1:0]         req_a_i,
  input  logic [2*XLEN-1:0]         req_b_i,
  input  logic [2*MDU_OP_WIDTH-1:0] req_op_i,
  input  logic [1:0]                flush_i,
  output logic [1:0]                rsp_valid_o,
  output logic [XLEN-1:0]           rsp_result_o,
  output logic                      mdu_req_o,
  output logic [XLEN-1:0]           mdu_port_a_o,
  output logic [XLEN-1:0]           mdu_port_b_o,
  output logic [MDU_OP_WIDTH-1:0]   mdu_op_o,
  output logic                      mdu_kill_o,
  output logic                      mdu_keep_o,
  input  logic [XLEN-1:0]           mdu_result_i,
  input  logic                      mdu_stall_req_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_last_grant;
  logic                    r_owner;
  logic [XLEN-1:0]         r_a;
  logic [XLEN-1:0]         r_b;
  logic [XLEN-1:0]         r_result;
  logic [MDU_OP_WIDTH-1:0] r_op;

  logic w_grant;
  logic w_accept;
  logic w_flush_own;
  logic w_complete;

  // Requester accept is gated by reset so nothing is granted while it is held.
  assign w_grant     = (req_valid_i == 2'b11) ? ~r_last_grant : req_valid_i[1];
  assign w_accept    = (r_state == ST_IDLE) && (|req_valid_i) && arstn_i;
  assign w_flush_own = (r_state == ST_BUSY) && flush_i[r_owner];
  assign w_complete  = (r_state == ST_BUSY) && !flush_i[r_owner] && !mdu_stall_req_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_owner      <= w_grant;
        r_a          <= w_grant ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
        r_b          <= w_grant ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
        r_op         <= w_grant ? req_op_i[2*MDU_OP_WIDTH-1:MDU_OP_WIDTH]
                                : req_op_i[MDU_OP_WIDTH-1:0];
      end
      if (w_complete) begin
        r_result <= mdu_result_i;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 2'b00;
    rsp_valid_o  = 2'b00;
    rsp_result_o = '0;
    mdu_req_o    = 1'b0;
    mdu_kill_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          req_ready_o  = w_grant ? 2'b10 : 2'b01;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Flush wins over a completion landing in the same cycle.
        if (w_flush_own) begin
          mdu_kill_o   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          mdu_req_o = 1'b1;
          if (!mdu_stall_req_i) begin
            w_state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rsp_valid_o  = r_owner ? 2'b10 : 2'b01;
        rsp_result_o = r_result;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign mdu_port_a_o = r_a;
  assign mdu_port_b_o = r_b;
  assign mdu_op_o     = r_op;
  assign mdu_keep_o   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_mdu_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_miriscv_mdu_arb
// Purpose  : Directed self-checking bench for the two-requester MDU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_miriscv_mdu_arb;

  localparam int XLEN = 32;
  localparam int OPW  = 3;
  localparam logic [OPW-1:0] MDU_MUL = 3'b000;
  localparam logic [OPW-1:0] MDU_DIV = 3'b100;

  logic              clk_i = 1'b0;
  logic              arstn_i;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [2*XLEN-1:0] req_a_i;
  logic [2*XLEN-1:0] req_b_i;
  logic [2*OPW-1:0]  req_op_i;
  logic [1:0]        flush_i;
  logic [1:0]        rsp_valid_o;
  logic [XLEN-1:0]   rsp_result_o;
  logic              mdu_req_o;
  logic [XLEN-1:0]   mdu_port_a_o;
  logic [XLEN-1:0]   mdu_port_b_o;
  logic [OPW-1:0]    mdu_op_o;
  logic              mdu_kill_o;
  logic              mdu_keep_o;
  logic [XLEN-1:0]   mdu_result_i;
  logic              mdu_stall_req_i;

  int vectors    = 0;
  int miscompares = 0;

  miriscv_mdu_arb #(.XLEN(XLEN), .MDU_OP_WIDTH(OPW)) dut (
    .clk_i           (clk_i),
    .arstn_i         (arstn_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_a_i         (req_a_i),
    .req_b_i         (req_b_i),
    .req_op_i        (req_op_i),
    .flush_i         (flush_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_result_o    (rsp_result_o),
    .mdu_req_o       (mdu_req_o),
    .mdu_port_a_o    (mdu_port_a_o),
    .mdu_port_b_o    (mdu_port_b_o),
    .mdu_op_o        (mdu_op_o),
    .mdu_kill_o      (mdu_kill_o),
    .mdu_keep_o      (mdu_keep_o),
    .mdu_result_i    (mdu_result_i),
    .mdu_stall_req_i (mdu_stall_req_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    arstn_i = 1'b0; req_valid_i = 2'b11; flush_i = 2'b00;
    req_a_i = '0; req_b_i = '0; req_op_i = '0;
    mdu_result_i = '0; mdu_stall_req_i = 1'b0;
    #3;
    vectors++;
    if ({req_ready_o, rsp_valid_o, mdu_req_o, mdu_kill_o, mdu_keep_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {req_ready_o, rsp_valid_o, mdu_req_o, mdu_kill_o, mdu_keep_o});
    end
    vectors++;
    if ({rsp_result_o, mdu_port_a_o, mdu_port_b_o, mdu_op_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got a=%0d b=%0d op=%0d res=%0d want 0", mdu_port_a_o, mdu_port_b_o, mdu_op_o, rsp_result_o);
    end
    next_cycle();
    arstn_i = 1'b1; req_valid_i = 2'b00;
  endtask

  task automatic test_contention;
    logic [1:0] exp_g;
    req_a_i = {32'd222, 32'd111};
    req_b_i = {32'd4, 32'd3};
    req_op_i = {MDU_MUL, MDU_MUL};
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      next_cycle();
      req_valid_i = 2'b11; mdu_stall_req_i = 1'b0;
      #1;
      vectors++;
      if (req_ready_o !== exp_g) begin
        miscompares++;
        $display("FAIL cont_grant[%0d]: got %b want %b", i, req_ready_o, exp_g);
      end
      next_cycle();
      mdu_result_i = 32'd500 + i;
      #1;
      vectors++;
      if ({mdu_req_o, req_ready_o} !== 3'b100 || mdu_port_a_o !== (exp_g[1] ? 32'd222 : 32'd111)) begin
        miscompares++;
        $display("FAIL cont_busy[%0d]: got req=%b rdy=%b a=%0d", i, mdu_req_o, req_ready_o, mdu_port_a_o);
      end
      next_cycle();
      #1;
      vectors++;
      if (rsp_valid_o !== exp_g || rsp_result_o !== 32'd500 + i || req_ready_o !== 2'b00 || mdu_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL cont_resp[%0d]: got v=%b r=%0d rdy=%b req=%b want v=%b r=%0d", i, rsp_valid_o, rsp_result_o, req_ready_o, mdu_req_o, exp_g, 500 + i);
      end
    end
    next_cycle();
    req_valid_i = 2'b00;
  endtask

  task automatic test_single;
    req_valid_i = 2'b01; req_a_i = {32'd0, 32'd7}; req_b_i = {32'd0, 32'd6};
    req_op_i = {MDU_DIV, MDU_MUL};
    #1;
    vectors++;
    if (req_ready_o !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 01", req_ready_o);
    end
    next_cycle();
    req_valid_i = 2'b00; mdu_stall_req_i = 1'b0; mdu_result_i = 32'd42;
    #1;
    vectors++;
    if (mdu_req_o !== 1'b1 || mdu_port_a_o !== 32'd7 || mdu_port_b_o !== 32'd6 || mdu_op_o !== MDU_MUL) begin
      miscompares++;
      $display("FAIL single_busy: got req=%b a=%0d b=%0d op=%0d want 1 7 6 0", mdu_req_o, mdu_port_a_o, mdu_port_b_o, mdu_op_o);
    end
    next_cycle();
    mdu_result_i = 32'hDEAD;
    #1;
    vectors++;
    if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd42 || mdu_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_resp: got v=%b r=%0d req=%b want 01 42 0", rsp_valid_o, rsp_result_o, mdu_req_o);
    end
    next_cycle();
    #1;
    vectors++;
    if (rsp_valid_o !== 2'b00 || rsp_result_o !== '0) begin
      miscompares++;
      $display("FAIL single_idle: got v=%b r=%0d want 00 0", rsp_valid_o, rsp_result_o);
    end
  endtask

  task automatic test_long_div;
    next_cycle();
    req_valid_i = 2'b10; req_a_i = {32'd100, 32'd1}; req_b_i = {32'd7, 32'd1};
    req_op_i = {MDU_DIV, MDU_MUL};
    #1;
    vectors++;
    if (req_ready_o !== 2'b10) begin
      miscompares++;
      $display("FAIL div_ready: got %b want 10", req_ready_o);
    end
    for (int i = 0; i < 33; i++) begin
      next_cycle();
      req_valid_i = 2'b00; mdu_stall_req_i = 1'b1; mdu_result_i = 32'hBAD0 + i;
      #1;
      vectors++;
      if (mdu_req_o !== 1'b1 || mdu_port_a_o !== 32'd100 || mdu_port_b_o !== 32'd7 || mdu_op_o !== MDU_DIV || rsp_valid_o !== 2'b00) begin
        miscompares++;
        $display("FAIL div_stall[%0d]: got req=%b a=%0d b=%0d op=%0d v=%b", i, mdu_req_o, mdu_port_a_o, mdu_port_b_o, mdu_op_o, rsp_valid_o);
      end
    end
    next_cycle();
    mdu_stall_req_i = 1'b0; mdu_result_i = 32'd14;
    next_cycle();
    #1;
    vectors++;
    if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd14) begin
      miscompares++;
      $display("FAIL div_resp: got v=%b r=%0d want 10 14", rsp_valid_o, rsp_result_o);
    end
  endtask

  task automatic test_flush;
    next_cycle();
    req_valid_i = 2'b01; req_a_i = {32'd9, 32'd50}; req_b_i = {32'd3, 32'd5};
    req_op_i = {MDU_MUL, MDU_DIV};
    next_cycle();
    req_valid_i = 2'b10; mdu_stall_req_i = 1'b1; flush_i = 2'b01;
    #1;
    vectors++;
    if (mdu_kill_o !== 1'b1 || mdu_req_o !== 1'b0 || req_ready_o !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_kill: got kill=%b req=%b rdy=%b want 1 0 00", mdu_kill_o, mdu_req_o, req_ready_o);
    end
    next_cycle();
    flush_i = 2'b00;
    #1;
    vectors++;
    if (rsp_valid_o !== 2'b00 || mdu_kill_o !== 1'b0 || req_ready_o !== 2'b10) begin
      miscompares++;
      $display("FAIL flush_next: got v=%b kill=%b rdy=%b want 00 0 10", rsp_valid_o, mdu_kill_o, req_ready_o);
    end
    // A flush aimed at the non-owner must not disturb requester 1's operation.
    next_cycle();
    req_valid_i = 2'b00; flush_i = 2'b01; mdu_stall_req_i = 1'b0; mdu_result_i = 32'd27;
    #1;
    vectors++;
    if (mdu_kill_o !== 1'b0 || mdu_req_o !== 1'b1 || mdu_port_a_o !== 32'd9) begin
      miscompares++;
      $display("FAIL flush_nonowner: got kill=%b req=%b a=%0d want 0 1 9", mdu_kill_o, mdu_req_o, mdu_port_a_o);
    end
    next_cycle();
    flush_i = 2'b00;
    #1;
    vectors++;
    if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd27) begin
      miscompares++;
      $display("FAIL flush_resp: got v=%b r=%0d want 10 27", rsp_valid_o, rsp_result_o);
    end
  endtask

  task automatic test_flush_complete;
    next_cycle();
    req_valid_i = 2'b01;
    next_cycle();
    req_valid_i = 2'b00; mdu_stall_req_i = 1'b0; flush_i = 2'b01; mdu_result_i = 32'd99;
    #1;
    vectors++;
    if (mdu_kill_o !== 1'b1 || mdu_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fc_kill: got kill=%b req=%b want 1 0", mdu_kill_o, mdu_req_o);
    end
    // Back in IDLE: flush held high must not mask a new request.
    next_cycle();
    req_valid_i = 2'b01;
    #1;
    vectors++;
    if (rsp_valid_o !== 2'b00 || rsp_result_o !== '0 || req_ready_o !== 2'b01 || mdu_kill_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fc_idle: got v=%b r=%0d rdy=%b kill=%b want 00 0 01 0", rsp_valid_o, rsp_result_o, req_ready_o, mdu_kill_o);
    end
  endtask

  task automatic test_reset_busy;
    next_cycle();
    req_valid_i = 2'b11; flush_i = 2'b00; mdu_stall_req_i = 1'b1;
    #1;
    vectors++;
    if (mdu_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rb_busy: got req=%b want 1", mdu_req_o);
    end
    arstn_i = 1'b0;
    #1;
    vectors++;
    if ({req_ready_o, rsp_valid_o, mdu_req_o, mdu_kill_o} !== 6'b0 || mdu_port_a_o !== '0 || mdu_port_b_o !== '0) begin
      miscompares++;
      $display("FAIL rb_async: got rdy=%b v=%b req=%b kill=%b a=%0d", req_ready_o, rsp_valid_o, mdu_req_o, mdu_kill_o, mdu_port_a_o);
    end
    next_cycle();
    #1;
    vectors++;
    if ({req_ready_o, rsp_valid_o, mdu_req_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL rb_held: got rdy=%b v=%b req=%b want 0", req_ready_o, rsp_valid_o, mdu_req_o);
    end
    arstn_i = 1'b1;
    #1;
    vectors++;
    if (req_ready_o !== 2'b01) begin
      miscompares++;
      $display("FAIL rb_first_grant: got %b want 01", req_ready_o);
    end
    next_cycle();
    req_valid_i = 2'b00; mdu_stall_req_i = 1'b0; mdu_result_i = 32'd5;
    next_cycle();
    #1;
    vectors++;
    if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd5) begin
      miscompares++;
      $display("FAIL rb_resp: got v=%b r=%0d want 01 5", rsp_valid_o, rsp_result_o);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_long_div();
    test_flush();
    test_flush_complete();
    test_reset_busy();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/miriscv_mdu_arb.md
MIRISCV_MDU_ARB -- requirements
Module: miriscv_mdu_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL have parameter MDU_OP_WIDTH, default 3, meaning opcode width (miriscv_mdu_pkg encoding).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port arstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  2  per-requester request valid (bit 0 = requester 0).
REQ-006 SHALL have port req_ready_o  output  2  per-requester accept pulse.
REQ-007 SHALL have ports req_a_i / req_b_i  input  2*XLEN each  operands, requester n in bits [n*XLEN +: XLEN].
REQ-008 SHALL have port req_op_i  input  2*MDU_OP_WIDTH  opcodes, requester n in bits [n*MDU_OP_WIDTH +: MDU_OP_WIDTH].
REQ-009 SHALL have port flush_i  input  2  per-requester cancel of its in-flight operation.
REQ-010 SHALL have port rsp_valid_o  output  2  one-cycle result-valid pulse to the owning requester.
REQ-011 SHALL have port rsp_result_o  output  XLEN  result, shared by both requesters, qualified by rsp_valid_o.
REQ-012 SHALL have ports mdu_req_o (1), mdu_port_a_o (XLEN), mdu_port_b_o (XLEN), mdu_op_o (MDU_OP_WIDTH), mdu_kill_o (1), mdu_keep_o (1)  output  drive the shared MDU.
REQ-013 SHALL have ports mdu_result_i (XLEN) and mdu_stall_req_i (1)  input  MDU result and busy indication.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-015 IDLE: when req_valid_i is nonzero, SHALL grant one requester, assert req_ready_o for that bit only in the same cycle, latch its a/b/op and owner index, and go to BUSY.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant requester != last_grant; with one valid, grant it; last_grant resets to 1 so requester 0 wins first.
REQ-017 last_grant SHALL update only on an accept.
REQ-018 BUSY: SHALL drive mdu_req_o=1 with the latched operands and opcode, which are held stable for the whole of BUSY.
REQ-019 BUSY with mdu_stall_req_i=0 and flush_i[owner]=0: SHALL register mdu_result_i and go to RESP; the minimum accept-to-response latency is 2 cycles.
REQ-020 RESP: SHALL assert rsp_valid_o[owner] for exactly one cycle with the registered result, drive mdu_req_o=0, and return to IDLE.
REQ-021 No new request SHALL be accepted in BUSY or RESP, so there is a minimum 3-cycle issue interval.
REQ-022 BUSY with flush_i[owner]=1: SHALL assert mdu_kill_o=1 and mdu_req_o=0 in that cycle, go to IDLE, and produce no rsp_valid_o; flush has priority over completion in the same cycle.
REQ-023 flush_i for a non-owner, or in IDLE or RESP, SHALL be ignored; in IDLE it does not mask req_valid_i.
REQ-024 mdu_keep_o SHALL be constant 0.
REQ-025 mdu_kill_o SHALL be 0 except as required by REQ-022.
REQ-026 rsp_result_o SHALL be 0 whenever rsp_valid_o is 0.
REQ-027 req_ready_o and rsp_valid_o SHALL never have more than one bit set.

Reset
REQ-028 arstn_i low SHALL immediately force state=IDLE, last_grant=1, and zero all outputs and latched operand/result registers.
REQ-029 Reset mid-BUSY SHALL abandon the operation without a response, with mdu_req_o low while reset is held.

Verification
REQ-030 Single op: req_valid_i=01, a=7, b=6, op=MDU_MUL, MDU stall low on first BUSY cycle -> req_ready_o=01 at T, rsp_valid_o=01 with result 42 at T+2.
REQ-031 Contention: req_valid_i=11 held continuously -> grants alternate 01,10,01,10, each response routed to the granted requester's bit.
REQ-032 Long divide: requester 1, a=100, b=7, op=MDU_DIV, stall held 33 cycles -> mdu_req_o and operands stable throughout, rsp_valid_o=10 with result 14 one cycle after stall drops.
REQ-033 Flush: requester 0 DIV in BUSY, flush_i=01 -> mdu_kill_o=1 for one cycle, no rsp_valid_o, and a pending requester 1 is accepted in the next IDLE cycle.
REQ-034 Flush and completion in the same cycle (stall=0, flush_i[owner]=1) -> no response and mdu_kill_o=1.
REQ-035 Reset mid-BUSY -> all outputs 0 immediately; after release, req_valid_i=11 grants requester 0 first.
